// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and state types for the PS/2 mouse init sequencer
package ps2_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERR    = 8'hFC;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_RST,
    ST_W_ACK1,
    ST_W_BAT,
    ST_W_ID,
    ST_TX_EN,
    ST_W_ACK2,
    ST_DONE,
    ST_ERROR
  } init_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INH,
    TX_REQ,
    TX_BITS,
    TX_ACK,
    TX_WAIT
  } tx_state_t;

  function automatic logic [7:0] expected_rsp(input init_state_t s);
    case (s)
      ST_W_BAT: return RSP_BAT;
      ST_W_ID:  return RSP_ID;
      default:  return RSP_ACK;
    endcase
  endfunction

endpackage

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 byte transmitter with inhibit, request and ack check
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2518,
  parameter int unsigned RESP_TIMEOUT   = 12587500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       clk_s,
  input  logic       data_s,
  output logic       clk_oe,
  output logic       data_oe,
  output logic       done,
  output logic       fail
);

  localparam logic [23:0] INH_LAST = 24'(INHIBIT_CYCLES - 2);
  localparam logic [23:0] TMO_LAST = 24'(RESP_TIMEOUT - 1);

  tx_state_t   st, st_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  sh_q, sh_d;
  logic        data_q, data_d;
  logic        clk_prev;
  logic        fall;

  assign fall = clk_prev & ~clk_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      data_q   <= 1'b0;
      clk_prev <= 1'b1;
    end else begin
      st       <= st_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      clk_prev <= clk_s;
    end
  end

  always_comb begin
    st_d   = st;
    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    data_d = data_q;
    done   = 1'b0;
    fail   = 1'b0;
    // Our own inhibit pulls the clock low, so only device edges after release feed the watchdog
    if (fall && (st == TX_BITS || st == TX_ACK || st == TX_WAIT)) cnt_d = '0;
    case (st)
      TX_IDLE: cnt_d = '0;
      TX_INH:  if (cnt_q >= INH_LAST) st_d = TX_REQ;
      TX_REQ: begin
        st_d   = TX_BITS;
        data_d = 1'b1;
        bit_d  = '0;
      end
      TX_BITS: if (fall) begin
        if (bit_q == 4'd9) begin
          data_d = 1'b0;
          st_d   = TX_ACK;
        end else begin
          data_d = ~sh_q[0];
          sh_d   = sh_q >> 1;
          bit_d  = bit_q + 4'd1;
        end
      end
      TX_ACK: if (fall) begin
        if (data_s) begin
          fail = 1'b1;
          st_d = TX_IDLE;
        end else begin
          st_d = TX_WAIT;
        end
      end
      TX_WAIT: if (clk_s && data_s) begin
        done = 1'b1;
        st_d = TX_IDLE;
      end
      default: st_d = TX_IDLE;
    endcase
    if (st != TX_IDLE && st_d != TX_IDLE && cnt_q >= TMO_LAST && !fall) begin
      fail = 1'b1;
      st_d = TX_IDLE;
    end
    if (st_d != st) cnt_d = '0;
    if (go) begin
      st_d   = TX_INH;
      cnt_d  = '0;
      bit_d  = '0;
      sh_d   = {~^tx_byte, tx_byte};
      data_d = 1'b0;
      done   = 1'b0;
      fail   = 1'b0;
    end
  end

  assign clk_oe  = (st == TX_INH) || (st == TX_REQ);
  assign data_oe = (st == TX_REQ) || ((st == TX_BITS) && data_q);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// rtl/ps2_mouse_init_ctrl.sv - sequencer that resets the PS/2 mouse and enables stream mode
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2518,
  parameter int unsigned RESP_TIMEOUT   = 12587500,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       stream_en,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [1:0] retry_cnt
);

  localparam logic [23:0] TMO_LAST  = 24'(RESP_TIMEOUT - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);

  init_state_t state, state_d;
  logic [1:0]  clk_sync, data_sync;
  logic [1:0]  retry_q, retry_d;
  logic [1:0]  resend_q, resend_d;
  logic [23:0] tmo_q;
  logic        done_q, done_d, err_q, err_d;
  logic        go_rst, go_en, fail;
  logic        tx_go, tx_done, tx_fail;
  logic [7:0]  tx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      retry_q  <= '0;
      resend_q <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      retry_q  <= retry_d;
      resend_q <= resend_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (state_d != state) tmo_q <= '0;
      else if (tmo_q != '1) tmo_q <= tmo_q + 24'd1;
    end
  end

  always_comb begin
    state_d  = state;
    retry_d  = retry_q;
    resend_d = resend_q;
    done_d   = done_q;
    err_d    = err_q;
    go_rst   = 1'b0;
    go_en    = 1'b0;
    fail     = 1'b0;
    case (state)
      ST_IDLE: if (AUTO_START) go_rst = 1'b1;
      ST_TX_RST: begin
        if (tx_fail) fail = 1'b1;
        else if (tx_done) state_d = ST_W_ACK1;
      end
      ST_TX_EN: begin
        if (tx_fail) fail = 1'b1;
        else if (tx_done) state_d = ST_W_ACK2;
      end
      ST_W_ACK1, ST_W_BAT, ST_W_ID, ST_W_ACK2: begin
        if (rx_valid) begin
          if (rx_byte == expected_rsp(state)) begin
            resend_d = '0;
            case (state)
              ST_W_ACK1: state_d = ST_W_BAT;
              ST_W_BAT:  state_d = ST_W_ID;
              ST_W_ID:   go_en = 1'b1;
              default: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            endcase
          end else if (rx_byte == RSP_RESEND && resend_q != 2'd2) begin
            // Only a third back-to-back resend is charged as a retry
            resend_d = resend_q + 2'd1;
            if (state == ST_W_ACK2) go_en = 1'b1;
            else go_rst = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (tmo_q >= TMO_LAST) begin
          fail = 1'b1;
        end
      end
      default: ;
    endcase
    if (fail) begin
      resend_d = '0;
      if (retry_q == RETRY_MAX) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        retry_d = retry_q + 2'd1;
        go_rst  = 1'b1;
      end
    end
    if (start) begin
      done_d   = 1'b0;
      err_d    = 1'b0;
      retry_d  = '0;
      resend_d = '0;
      go_rst   = 1'b1;
      go_en    = 1'b0;
    end
    if (go_rst) state_d = ST_TX_RST;
    else if (go_en) state_d = ST_TX_EN;
  end

  assign tx_go   = go_rst | go_en;
  assign tx_byte = go_en ? CMD_ENABLE : CMD_RESET;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT_CYCLES),
    .RESP_TIMEOUT  (RESP_TIMEOUT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .go     (tx_go),
    .tx_byte(tx_byte),
    .clk_s  (clk_sync[1]),
    .data_s (data_sync[1]),
    .clk_oe (ps2_clk_oe),
    .data_oe(ps2_data_oe),
    .done   (tx_done),
    .fail   (tx_fail)
  );

  assign stream_en  = (state == ST_DONE);
  assign busy       = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign init_done  = done_q;
  assign init_error = err_q;
  assign retry_cnt  = retry_q;

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
Host-side sequencer that brings the PS/2 mouse on uio[1:0] out of reset and into stream mode before the packet decoder runs. It drives the open-drain clock/data lines for host-to-device commands (0xFF reset, 0xF4 enable reporting) and checks device replies from the existing byte receiver. It gates that receiver and the decoder through stream_en and handles retries and timeouts.

Parameters:
INHIBIT_CYCLES, 2518, clk cycles the clock line is held low before a command (100 us at 25.175 MHz)
RESP_TIMEOUT, 12587500, max clk cycles waiting for a reply byte or a device clock edge (500 ms)
MAX_RETRIES, 3, full-sequence restarts before declaring error
AUTO_START, 1, 1 = begin the sequence on the first cycle after reset

Ports:
clk  in  1  system clock (25.175 MHz)
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; restarts the sequence from any state
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low
ps2_data_oe  out  1  1 = pull data line low
rx_valid  in  1  one-cycle strobe from the byte receiver
rx_byte  in  8  received byte, valid with rx_valid
stream_en  out  1  high only in DONE; enables the receiver and decoder
busy  out  1  high in any state except IDLE, DONE, ERROR
init_done  out  1  sticky success flag
init_error  out  1  sticky failure flag
retry_cnt  out  2  number of full-sequence restarts used

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Synchronisation: 2-FF synchronizer on each PS/2 input. Falling edge of the synchronized clock = prev 1 and cur 0.
- Top FSM states: IDLE -> TX_RST -> W_ACK1 -> W_BAT -> W_ID -> TX_EN -> W_ACK2 -> DONE; plus ERROR.
  - IDLE exits when AUTO_START is set (first cycle after reset) or on a start pulse.
  - W_ACK expects 0xFA. W_BAT expects 0xAA. W_ID expects 0x00.
- Reply handling in a W_* state:
  - 0xFE (resend): re-enter the preceding TX state. Counts as a retry only if more than 2 consecutive 0xFE replies occur.
  - 0xFC, any other unexpected byte, or a timeout (counter reaches RESP_TIMEOUT with no rx_valid): full restart.
  - Full restart: retry_cnt+1, go to TX_RST. If retry_cnt already equals MAX_RETRIES, go to ERROR instead.
- rx_valid is ignored in TX states, IDLE, DONE and ERROR.
- DONE: stream_en=1, init_done=1.
- ERROR: init_error=1, both oe low. Leaves only on start or rst.
- start in any state: clears init_done, init_error and retry_cnt; drops stream_en; releases both lines; goes to TX_RST. No wait for the current frame to finish.
- Transmit sub-FSM, used by both TX states. States: INH -> REQ -> BITS -> ACK -> WAIT_IDLE.
  - INH: ps2_clk_oe=1 for exactly INHIBIT_CYCLES clocks.
  - REQ: ps2_data_oe=1 (start bit), then ps2_clk_oe=0 on the following cycle.
  - BITS, on each device falling edge n (1-based):
    - n=1..8: ps2_data_oe = ~D[n-1], LSB first.
    - n=9: ps2_data_oe = ~odd parity bit (parity = ~^D).
    - n=10: ps2_data_oe=0 (stop).
  - ACK: on falling edge 11, sample data. 0 = ack; 1 = fail, treated as a timeout (full restart).
  - WAIT_IDLE: wait until both synchronized lines are high, then hand back to the top FSM.
  - Every TX sub-state has a RESP_TIMEOUT watchdog that restarts on each falling edge; expiry = full restart.
- Counters: the timeout counter is 24 bits, saturating. The bit counter is 4 bits.
- Mid-operation reset releases both lines immediately, since the reset is asynchronous.

Decomposition:
- Package ps2_pkg holds:
  - Constants: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA, RSP_BAT=8'hAA, RSP_ID=8'h00, RSP_RESEND=8'hFE, RSP_ERR=8'hFC.
  - The top-FSM state enum.
- Sub-module ps2_host_tx implements the transmit sub-FSM.
  - Inputs: clk, rst, go, byte, synchronized lines.
  - Outputs: clk_oe, data_oe, done, fail.

Test Plan:
- Device model ACKs 0xFF, replies FA, AA, 00, ACKs 0xF4, replies FA -> init_done=1, stream_en=1, retry_cnt=0. Data bits captured by the model = 0xFF then 0xF4. Parity bits = 1 then 0.
- Bench INHIBIT_CYCLES=20 -> ps2_clk_oe held exactly 20 cycles. data_oe asserts before clk_oe releases.
- Reply 0xFE once after 0xF4 -> 0xF4 resent, then DONE with retry_cnt=0.
- Model silent after 0xFF (RESP_TIMEOUT=2000), MAX_RETRIES=3 -> three restarts, retry_cnt=3, then ERROR: init_error=1, lines released, stream_en=0.
- W_BAT receives 0xFC -> restart at TX_RST with retry_cnt=1. Next pass succeeds -> init_done=1.
- start pulse in DONE -> stream_en drops the next cycle, flags clear, clock inhibit begins. rst asserted mid-BITS -> both oe outputs 0 in the same cycle.
